ahb_slave_decoder_mux: RTL
==========================

Name: ahb_slave_decoder_mux

Overview:
- AHB-Lite address decoder plus slave response multiplexer for one bus-matrix output port with three slaves and one default slave.
- Address phase: decodes HADDR into one-hot HSEL outputs. Data phase: registers the selection and steers the selected slave's HREADYOUT, HRESP and HRDATA back to the master.
- Unmapped addresses go to the default slave.
- A wait-state watchdog aborts a stalled slave with a two-cycle ERROR response.

Parameters:
- S0_BASE, 32'h0000_0000, slave 0 match value
- S0_MASK, 32'hE000_0000, slave 0 address mask
- S1_BASE, 32'h2000_0000, slave 1 match value
- S1_MASK, 32'hE000_0000, slave 1 address mask
- S2_BASE, 32'h4000_0000, slave 2 match value
- S2_MASK, 32'hF000_0000, slave 2 address mask
- TIMEOUT_CYCLES, 16, consecutive stalled data-phase cycles before abort (legal range 1..255)

Ports:
- HCLK  in  1  AHB system clock
- HRESET  in  1  reset, synchronous, active-high
- HADDR  in  32  address-phase address
- HTRANS  in  2  transfer type
- HREADY  in  1  bus HREADY (externally tied to HREADY_OUT)
- HSEL_S0, HSEL_S1, HSEL_S2, HSEL_DEF  out  1 each  combinational slave selects
- HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_DEF  in  1 each  slave ready
- HRESP_S0, HRESP_S1, HRESP_S2, HRESP_DEF  in  2 each  slave response (00 OKAY, 01 ERROR)
- HRDATA_S0, HRDATA_S1, HRDATA_S2  in  32 each  slave read data
- HREADY_OUT  out  1  muxed ready to master
- HRESP_OUT  out  2  muxed response to master
- HRDATA_OUT  out  32  muxed read data
- TIMEOUT_EVT  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Decode (combinational, independent of HTRANS):
  - Slave n matches when (HADDR & Sn_MASK) == Sn_BASE.
  - Priority is S0 > S1 > S2. No match asserts HSEL_DEF.
  - Exactly one HSEL is high at all times.
- Data-phase select register dsel (one-hot, 4 bits) and dtrans (HTRANS[1]):
  - Both load on posedge HCLK when HREADY=1; otherwise they hold.
  - Reset: dsel=0000 (none), dtrans=0.
- Response mux:
  - dsel=none: HREADY_OUT=1, HRESP_OUT=00, HRDATA_OUT=0.
  - Otherwise the outputs follow the selected slave.
  - Default slave: HRDATA_OUT=0.
- Watchdog FSM, states NORMAL, ERR1, ERR2. Reset state NORMAL, counter=0.
  - NORMAL:
    - Counter increments each cycle where dtrans=1 and the muxed slave HREADYOUT=0. Otherwise it clears to 0.
    - When the counter is at TIMEOUT_CYCLES-1 and the slave is still stalled: go to ERR1, pulse TIMEOUT_EVT for that cycle, clear the counter.
  - ERR1: HREADY_OUT=0, HRESP_OUT=01, HRDATA_OUT=0. Always go to ERR2 next.
  - ERR2: HREADY_OUT=1, HRESP_OUT=01. dsel/dtrans load the next address phase here as normal. Always go to NORMAL next.
  - Slave inputs are ignored during ERR1 and ERR2.
  - A slave that readies in the same cycle the watchdog fires still gets the abort; the watchdog has priority.
- Reset outputs: HREADY_OUT=1, HRESP_OUT=00, HRDATA_OUT=0, TIMEOUT_EVT=0. HSEL outputs follow HADDR.
- Reset mid-transfer: dsel, dtrans, FSM and counter all clear on the next edge regardless of HREADY. The pending data phase is dropped.
- IDLE and BUSY data phases are routed but never counted by the watchdog.
- No added latency: the response path is combinational from the slave inputs through the registered dsel.

Test Plan:
- Decode: HADDR=0x0000_1000, 0x2000_0004, 0x4000_0008, 0x8000_0000 with HTRANS=NONSEQ. Required: HSEL_S0, HSEL_S1, HSEL_S2, HSEL_DEF respectively, one-hot. Next-cycle HRDATA_OUT equals the matching slave's data.
- Wait states: slave 1 holds HREADYOUT low for 3 cycles, then returns 0xDEADBEEF. Required: HREADY_OUT low for 3 cycles; dsel holds even though HADDR changes to 0x0000_0000; then HRDATA_OUT=0xDEADBEEF with HRESP_OUT=00.
- Unmapped access: NONSEQ to 0x9000_0000, default slave returns its two-cycle ERROR. Required: HRESP_OUT=01 with HREADY_OUT 0 then 1, passed through unchanged.
- Watchdog: slave 2 stalls indefinitely, TIMEOUT_CYCLES=16. Required: 16 stall cycles, then TIMEOUT_EVT pulse, ERR1 (HREADY_OUT=0, HRESP_OUT=01), then ERR2 (HREADY_OUT=1, HRESP_OUT=01), then back to normal routing.
- Boundary: slave readies in exactly the 16th stall cycle. Required: abort still occurs. With a ready in the 15th cycle instead: no abort, counter cleared.
- Reset: HRESET asserted for 1 cycle during a stalled slave 0 data phase. Required: next cycle HREADY_OUT=1, HRESP_OUT=00, HRDATA_OUT=0, TIMEOUT_EVT=0, no abort sequence.

Source files
------------

// File: rtl/ahb_slave_decoder_mux.sv
// AHB-Lite decoder and response multiplexer for one output port: three mapped slaves plus a
// default slave, with a wait-state watchdog that aborts a stalled slave with an ERROR response.
module ahb_slave_decoder_mux #(
  parameter logic [31:0] S0_BASE        = 32'h0000_0000,
  parameter logic [31:0] S0_MASK        = 32'hE000_0000,
  parameter logic [31:0] S1_BASE        = 32'h2000_0000,
  parameter logic [31:0] S1_MASK        = 32'hE000_0000,
  parameter logic [31:0] S2_BASE        = 32'h4000_0000,
  parameter logic [31:0] S2_MASK        = 32'hF000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  output logic        HSEL_S0,
  output logic        HSEL_S1,
  output logic        HSEL_S2,
  output logic        HSEL_DEF,
  input  logic        HREADYOUT_S0,
  input  logic        HREADYOUT_S1,
  input  logic        HREADYOUT_S2,
  input  logic        HREADYOUT_DEF,
  input  logic [1:0]  HRESP_S0,
  input  logic [1:0]  HRESP_S1,
  input  logic [1:0]  HRESP_S2,
  input  logic [1:0]  HRESP_DEF,
  input  logic [31:0] HRDATA_S0,
  input  logic [31:0] HRDATA_S1,
  input  logic [31:0] HRDATA_S2,
  output logic        HREADY_OUT,
  output logic [1:0]  HRESP_OUT,
  output logic [31:0] HRDATA_OUT,
  output logic        TIMEOUT_EVT
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_ERR1   = 2'd1,
    ST_ERR2   = 2'd2
  } wd_state_t;

  localparam logic [7:0] LAST_CNT  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  // Address-phase decode
  logic [2:0]  w_match;
  logic [3:0]  w_hsel;

  assign w_match[0] = ((HADDR & S0_MASK) == S0_BASE);
  assign w_match[1] = ((HADDR & S1_MASK) == S1_BASE);
  assign w_match[2] = ((HADDR & S2_MASK) == S2_BASE);

  assign w_hsel[0] = w_match[0];
  assign w_hsel[1] = !w_match[0] && w_match[1];
  assign w_hsel[2] = !w_match[0] && !w_match[1] && w_match[2];
  assign w_hsel[3] = !(|w_match);

  assign HSEL_S0  = w_hsel[0];
  assign HSEL_S1  = w_hsel[1];
  assign HSEL_S2  = w_hsel[2];
  assign HSEL_DEF = w_hsel[3];

  // Data-phase state
  logic [3:0]  r_dsel;
  logic        r_dtrans;
  wd_state_t   r_state;
  wd_state_t   w_state_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dsel   <= 4'b0000;
      r_dtrans <= 1'b0;
      r_state  <= ST_NORMAL;
      r_cnt    <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (HREADY) begin
        r_dsel   <= w_hsel;
        r_dtrans <= HTRANS[1];
      end
    end
  end

  // Slave response mux; no selection (after reset) behaves as an idle, ready bus
  logic        w_slv_ready;
  logic [1:0]  w_slv_resp;
  logic [31:0] w_slv_rdata;

  always_comb begin
    w_slv_ready = 1'b1;
    w_slv_resp  = RESP_OKAY;
    w_slv_rdata = 32'd0;
    unique case (r_dsel)
      4'b0001: begin
        w_slv_ready = HREADYOUT_S0;
        w_slv_resp  = HRESP_S0;
        w_slv_rdata = HRDATA_S0;
      end
      4'b0010: begin
        w_slv_ready = HREADYOUT_S1;
        w_slv_resp  = HRESP_S1;
        w_slv_rdata = HRDATA_S1;
      end
      4'b0100: begin
        w_slv_ready = HREADYOUT_S2;
        w_slv_resp  = HRESP_S2;
        w_slv_rdata = HRDATA_S2;
      end
      4'b1000: begin
        w_slv_ready = HREADYOUT_DEF;
        w_slv_resp  = HRESP_DEF;
        w_slv_rdata = 32'd0;
      end
      default: ;
    endcase
  end

  logic w_stall;
  logic w_fire;

  assign w_stall = r_dtrans && !w_slv_ready;

  // Once the counter is at its last value the abort fires even if the slave readies now;
  // a zero count (only reachable at LAST_CNT when the limit is 1) still needs a real stall.
  assign w_fire = (r_state == ST_NORMAL) && r_dtrans && (r_cnt == LAST_CNT) &&
                  (w_stall || (r_cnt != 8'd0));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    HREADY_OUT   = w_slv_ready;
    HRESP_OUT    = w_slv_resp;
    HRDATA_OUT   = w_slv_rdata;
    unique case (r_state)
      ST_NORMAL: begin
        if (w_fire) begin
          w_state_next = ST_ERR1;
          w_cnt_next   = 8'd0;
          HREADY_OUT   = 1'b0;
          HRESP_OUT    = RESP_OKAY;
          HRDATA_OUT   = 32'd0;
        end else if (w_stall) begin
          w_cnt_next = r_cnt + 8'd1;
        end else begin
          w_cnt_next = 8'd0;
        end
      end
      ST_ERR1: begin
        w_state_next = ST_ERR2;
        w_cnt_next   = 8'd0;
        HREADY_OUT   = 1'b0;
        HRESP_OUT    = RESP_ERR;
        HRDATA_OUT   = 32'd0;
      end
      ST_ERR2: begin
        w_state_next = ST_NORMAL;
        w_cnt_next   = 8'd0;
        HREADY_OUT   = 1'b1;
        HRESP_OUT    = RESP_ERR;
        HRDATA_OUT   = 32'd0;
      end
      default: begin
        w_state_next = ST_NORMAL;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  assign TIMEOUT_EVT = w_fire;

  logic w_unused;
  assign w_unused = HTRANS[0];

endmodule
